// File: rtl/siso_shift_ctrl.sv
// Word-level sequencer for a DEPTH-stage serial-in/serial-out dff chain: serializes, flushes, collects.
// Optional build macro SISO_CTRL_CHECK_EN adds a `mismatch` output comparing the returned word to the sent one.
`timescale 1ns/1ps

module siso_shift_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sdo,
    output logic             shift_en,
    input  logic             sdi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef SISO_CTRL_CHECK_EN
    output logic             mismatch,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0]    RX_START = CW'(DEPTH);
    localparam logic [WIDTH-1:0] MSB_ONE  = WIDTH'(1) << (WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx_shreg;
    logic [WIDTH-1:0] rx_shreg;
`ifdef SISO_CTRL_CHECK_EN
    logic [WIDTH-1:0] sent_word;
`endif

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_shreg <= '0;
            rx_shreg <= '0;
`ifdef SISO_CTRL_CHECK_EN
            sent_word <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tx_shreg <= (MSB_FIRST != 0) ? in_data : bit_reverse(in_data);
`ifdef SISO_CTRL_CHECK_EN
                        sent_word <= in_data;
`endif
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Zero fill makes sdo flush the chain once the word is out.
                    tx_shreg <= tx_shreg << 1;
                    cnt      <= cnt + CW'(1);
                    // The first DEPTH chain outputs are stale; bit k of the word arrives at cnt==DEPTH+k.
                    if (cnt >= RX_START) begin
                        if (MSB_FIRST != 0) rx_shreg <= (rx_shreg << 1) | WIDTH'(sdi);
                        else                rx_shreg <= (rx_shreg >> 1) | (sdi ? MSB_ONE : '0);
                    end
                    if (cnt == CNT_LAST) state <= HOLD;
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registers only.
    assign in_ready  = (state == IDLE);
    assign shift_en  = (state == RUN);
    assign sdo       = shift_en & tx_shreg[WIDTH-1];
    assign out_valid = (state == HOLD);
    assign out_data  = out_valid ? rx_shreg : '0;
    assign busy      = (state != IDLE);
`ifdef SISO_CTRL_CHECK_EN
    assign mismatch  = out_valid && (rx_shreg != sent_word);
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Loopback bench: siso_shift_ctrl driving a 4-stage enabled dff chain model with an optional stuck-at-1 stage.
`timescale 1ns/1ps

module tb_siso_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       sdo;
    logic       shift_en;
    logic       sdi;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;
`ifdef SISO_CTRL_CHECK_EN
    logic       mismatch;
`endif

    int errors = 0;
    int checks = 0;

    logic [3:0] chain = '0;
    logic       stuck = 1'b0;

    always #5 clk = ~clk;

    siso_shift_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sdo      (sdo),
        .shift_en (shift_en),
        .sdi      (sdi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef SISO_CTRL_CHECK_EN
        .mismatch (mismatch),
`endif
        .busy     (busy)
    );

    // Chain model: stage 0 takes sdo, stage 3 drives sdi; stage 2 can be forced to 1.
    always @(posedge clk) begin
        if (shift_en) begin
            chain <= {chain[2:0], sdo};
            if (stuck) chain[2] <= 1'b1;
        end
    end
    assign sdi = chain[3];

    typedef struct {
        logic [7:0]  din;
        logic [7:0]  dout;
        logic [11:0] pat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers one word and waits for HOLD; returns what the DUT presents there.
    task automatic send_word(input logic [7:0] w, output logic [7:0] got, output int lat,
                             output int en_cnt, output logic [11:0] pat, output int bad);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        lat = 0; en_cnt = 0; pat = '0; bad = 0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            if (shift_en) begin
                en_cnt++;
                pat = {pat[10:0], sdo};
            end
            if (in_ready || !busy) bad++;
`ifdef SISO_CTRL_CHECK_EN
            if (mismatch) bad++;
`endif
            @(negedge clk);
            lat++;
        end
        check("hold_reached", out_valid, 1);
        got = out_data;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check(name, out_valid, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_shift_en"},  shift_en, 0);
        check({tag, "_sdo"},       sdo, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_out_data"},  out_data, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  got;
        logic [11:0] pat;
        int          lat, en_cnt, bad, guard;
        logic [7:0]  words[3];
        int          tx_i, rx_i, last_acc;
        bit          adv;

        vecs[0] = '{din: 8'hA5, dout: 8'hA5, pat: 12'hA50};
        vecs[1] = '{din: 8'h3C, dout: 8'h3C, pat: 12'h3C0};
        vecs[2] = '{din: 8'h00, dout: 8'h00, pat: 12'h000};
        vecs[3] = '{din: 8'hFF, dout: 8'hFF, pat: 12'hFF0};
        vecs[4] = '{din: 8'h81, dout: 8'h81, pat: 12'h810};
        vecs[5] = '{din: 8'h5A, dout: 8'h5A, pat: 12'h5A0};
        vecs[6] = '{din: 8'h01, dout: 8'h01, pat: 12'h010};

        // Reset held for two cycles.
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        // Loopback vectors (vector 0 is 8'hA5).
        for (int i = 0; i < 7; i++) begin
            send_word(vecs[i].din, got, lat, en_cnt, pat, bad);
            check($sformatf("vec%0d_data", i),     got, vecs[i].dout);
            check($sformatf("vec%0d_latency", i),  lat, 13);
            check($sformatf("vec%0d_shift_en", i), en_cnt, 12);
            check($sformatf("vec%0d_sdo", i),      pat, vecs[i].pat);
            check($sformatf("vec%0d_run_ctl", i),  bad, 0);
`ifdef SISO_CTRL_CHECK_EN
            check($sformatf("vec%0d_mismatch", i), mismatch, 0);
`endif
            drain($sformatf("vec%0d_release", i));
        end

        // Back-pressure: HOLD for 20 cycles while a new word is offered.
        send_word(8'h96, got, lat, en_cnt, pat, bad);
        check("bp_first_data", got, 8'h96);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!out_valid || out_data !== 8'h96 || shift_en || in_ready || sdo) bad++;
        end
        check("bp_hold_stable", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_valid", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", busy, 1);
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("bp_second_data", out_data, 8'h3C);
        drain("bp_release");

        // Back-to-back stream with out_ready held high.
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h81;
        tx_i = 0; rx_i = 0; last_acc = 0; adv = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && rx_i < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_valid = 1'b1;
                in_data  = words[0];
            end
            if (out_valid) begin
                check($sformatf("b2b%0d_data", rx_i), out_data, words[rx_i]);
                rx_i++;
            end
            if (adv) begin
                adv = 1'b0;
                if (tx_i < 3) in_data = words[tx_i];
                else          in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (tx_i > 0) check($sformatf("b2b%0d_period", tx_i), c - last_acc, 14);
                last_acc = c;
                tx_i++;
                adv = 1'b1;
            end
        end
        check("b2b_count", rx_i, 3);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_release", out_valid, 0);

        // Reset in the middle of RUN, at cnt==5.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_running", shift_en, 1);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b1;
        send_word(8'h5A, got, lat, en_cnt, pat, bad);
        check("midrst_next_data", got, 8'h5A);
        check("midrst_next_latency", lat, 13);
        drain("midrst_release");

        // Stage 2 stuck-at-1, then fault-free again.
        stuck = 1'b1;
        send_word(8'h00, got, lat, en_cnt, pat, bad);
        check("stuck_data", got, 8'hFF);
        check("stuck_run_ctl", bad, 0);
`ifdef SISO_CTRL_CHECK_EN
        check("stuck_mismatch_hold", mismatch, 1);
`endif
        drain("stuck_release");
`ifdef SISO_CTRL_CHECK_EN
        check("stuck_mismatch_idle", mismatch, 0);
`endif
        stuck = 1'b0;
        send_word(8'h00, got, lat, en_cnt, pat, bad);
        check("clean_data", got, 8'h00);
`ifdef SISO_CTRL_CHECK_EN
        check("clean_mismatch", mismatch, 0);
`endif
        drain("clean_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
